// File: rtl/soda_machine_types.sv
// Shared types for the soda machine.
//   insert_type         : coin code handed to soda_machine.insert (I0 means "no coin")
//   acceptor_state_type : control states of coin_acceptor
// Helpers map a one-hot rise vector {coin5, coin2, coin1} to a code and detect
// coincident coins.
package soda_machine_types;

    typedef enum logic [1:0] {
        I0 = 2'd0,
        I1 = 2'd1,
        I2 = 2'd2,
        I5 = 2'd3
    } insert_type;

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        REJECT,
        LOCKOUT,
        JAM
    } acceptor_state_type;

    localparam int NUM_COINS = 3;

    // Bit 0 = coin1, bit 1 = coin2, bit 2 = coin5.
    function automatic insert_type code_of(input logic [2:0] rise);
        insert_type code;
        code = I0;
        case (rise)
            3'b001:  code = I1;
            3'b010:  code = I2;
            3'b100:  code = I5;
            default: code = I0;
        endcase
        return code;
    endfunction

    // True when two or more bits are set.
    function automatic logic multi_hot(input logic [2:0] v);
        return (v & (v - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot channel: 2-flop synchronizer, debounce filter and high-time
// (jam) counter.
//   clk, reset : system clock, asynchronous active-high reset
//   raw        : raw bouncing sensor, asynchronous to clk
//   level      : debounced level
//   rise       : one-cycle pulse, coincident with level going 0->1
//   jammed     : debounced level has been high for JAM_CYCLES cycles (sticky
//                until level falls)
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic jammed
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int JW = $clog2(JAM_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [JW-1:0] JAM_MAX = JW'(JAM_CYCLES);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          rise_reg;
    logic [DW-1:0] db_cnt_reg;
    logic [JW-1:0] high_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            level_reg    <= 1'b0;
            rise_reg     <= 1'b0;
            db_cnt_reg   <= '0;
            high_cnt_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;

            // Disagreeing samples must be consecutive; one agreeing sample
            // restarts the count. The DEBOUNCE_CYCLES-th disagreement flips.
            if (sync2_reg != level_reg) begin
                if (db_cnt_reg == DB_LAST) begin
                    level_reg  <= sync2_reg;
                    rise_reg   <= sync2_reg;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DW'(1);
                end
            end else begin
                db_cnt_reg <= '0;
            end

            // Saturating high-time counter for jam detection.
            if (!level_reg) begin
                high_cnt_reg <= '0;
            end else if (high_cnt_reg != JAM_MAX) begin
                high_cnt_reg <= high_cnt_reg + JW'(1);
            end
        end
    end

    assign level  = level_reg;
    assign rise   = rise_reg;
    assign jammed = (high_cnt_reg == JAM_MAX);

endmodule

// File: rtl/coin_acceptor.sv
// Soda machine coin front end: turns three raw coin sensors into single-cycle
// insert codes, rejects coincident coins, enforces a post-coin lockout and
// reports jammed sensors.
//   clk, reset  : system clock, asynchronous active-high reset
//   coin1/2/5   : raw slot sensors (async, bouncing, active-high)
//   insert      : I1/I2/I5 for one cycle per accepted coin, else I0
//   coin_reject : one-cycle pulse per physically rejected coin
//   jam         : level, a sensor is stuck high
module coin_acceptor
    import soda_machine_types::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int JAM_CYCLES      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin1,
    input  logic       coin2,
    input  logic       coin5,
    output logic [1:0] insert,
    output logic       coin_reject,
    output logic       jam
);

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

    logic [NUM_COINS-1:0] raw_bus;
    logic [NUM_COINS-1:0] level_bus;
    logic [NUM_COINS-1:0] rise_bus;
    logic [NUM_COINS-1:0] jammed_bus;

    assign raw_bus = {coin5, coin2, coin1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COINS; gi++) begin : g_chan
            coin_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .JAM_CYCLES     (JAM_CYCLES)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_bus[gi]),
                .level (level_bus[gi]),
                .rise  (rise_bus[gi]),
                .jammed(jammed_bus[gi])
            );
        end
    endgenerate

    logic any_event;
    logic multi_event;
    logic jam_cond;
    logic all_low;

    assign any_event   = |rise_bus;
    assign multi_event = multi_hot(rise_bus);
    assign jam_cond    = |jammed_bus;
    assign all_low     = ~|level_bus;

    acceptor_state_type state_reg, state_next;
    insert_type         code_reg, code_next;
    logic [LW-1:0]      lock_cnt_reg, lock_cnt_next;
    // A coin that arrives during EMIT/REJECT is rejected on the following
    // cycle so that it never overlaps the current output pulse.
    logic               pending_reg, pending_next;
    insert_type         insert_reg, insert_next;
    logic               reject_reg, reject_next;
    logic               jam_reg, jam_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            code_reg     <= I0;
            lock_cnt_reg <= '0;
            pending_reg  <= 1'b0;
            insert_reg   <= I0;
            reject_reg   <= 1'b0;
            jam_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            lock_cnt_reg <= lock_cnt_next;
            pending_reg  <= pending_next;
            insert_reg   <= insert_next;
            reject_reg   <= reject_next;
            jam_reg      <= jam_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        code_next     = code_reg;
        lock_cnt_next = lock_cnt_reg;
        pending_next  = 1'b0;
        insert_next   = I0;
        reject_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (jam_cond) begin
                    state_next = JAM;
                end else if (multi_event) begin
                    state_next = REJECT;
                end else if (any_event) begin
                    state_next = EMIT;
                    code_next  = code_of(rise_bus);
                end
            end
            EMIT: begin
                insert_next   = code_reg;
                state_next    = LOCKOUT;
                lock_cnt_next = LOCK_LAST;
                pending_next  = any_event;
            end
            REJECT: begin
                reject_next   = 1'b1;
                state_next    = LOCKOUT;
                lock_cnt_next = LOCK_LAST;
                pending_next  = any_event;
            end
            LOCKOUT: begin
                reject_next = any_event | pending_reg;
                if (jam_cond) begin
                    state_next = JAM;
                end else if (any_event || pending_reg) begin
                    lock_cnt_next = LOCK_LAST;
                end else if (lock_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    lock_cnt_next = lock_cnt_reg - LW'(1);
                end
            end
            JAM: begin
                reject_next = any_event;
                if (all_low) begin
                    state_next    = LOCKOUT;
                    lock_cnt_next = LOCK_LAST;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // jam follows the state being entered, so it drops on the same edge
        // that leaves JAM.
        jam_next = (state_next == JAM);
    end

    assign insert      = insert_reg;
    assign coin_reject = reject_reg;
    assign jam         = jam_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor (DEBOUNCE=4, LOCKOUT=8, JAM=64).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge. Sample index c is the sample taken after the edge
// that first saw the inputs of step c.
module tb_coin_acceptor;

    logic       clk;
    logic       reset;
    logic       coin1;
    logic       coin2;
    logic       coin5;
    logic [1:0] insert;
    logic       coin_reject;
    logic       jam;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .LOCKOUT_CYCLES (8),
        .JAM_CYCLES     (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .coin1      (coin1),
        .coin2      (coin2),
        .coin5      (coin5),
        .insert     (insert),
        .coin_reject(coin_reject),
        .jam        (jam)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] C_I0 = 2'd0;
    localparam logic [1:0] C_I1 = 2'd1;
    localparam logic [1:0] C_I2 = 2'd2;
    localparam logic [1:0] C_I5 = 2'd3;

    typedef struct {
        string       name;
        logic [47:0] c1;
        logic [47:0] c2;
        logic [47:0] c5;
        int          n1;
        int          n2;
        int          n5;
        int          rej;
        int          first;
    } vec_t;

    vec_t vecs [9];

    int checks;
    int errors;

    int cyc;
    int n1, n2, n5, nrej;
    int first_ins;
    int jam_first, jam_last, jam_cnt;
    int viol;
    int rst_bad;
    logic [1:0] prev_ins;

    function automatic logic [47:0] span(input int lo, input int hi);
        logic [47:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic reset_stats();
        cyc       = 0;
        n1        = 0;
        n2        = 0;
        n5        = 0;
        nrej      = 0;
        first_ins = -1;
        jam_first = -1;
        jam_last  = -1;
        jam_cnt   = 0;
        viol      = 0;
        rst_bad   = 0;
        prev_ins  = C_I0;
    endtask

    // Drive one step, let one rising edge pass, sample on the falling edge.
    task automatic run_cycle(input logic a, input logic b, input logic c, input logic r);
        coin1 = a;
        coin2 = b;
        coin5 = c;
        reset = r;
        @(posedge clk);
        @(negedge clk);
        if (insert != C_I0) begin
            if (first_ins < 0) first_ins = cyc;
            if (insert == C_I1) n1++;
            if (insert == C_I2) n2++;
            if (insert == C_I5) n5++;
            if (prev_ins != C_I0) viol++;
            if (coin_reject) viol++;
        end
        if (coin_reject) nrej++;
        if (jam) begin
            if (jam_first < 0) jam_first = cyc;
            jam_last = cyc;
            jam_cnt++;
        end
        if (reset && (insert != C_I0 || coin_reject || jam)) rst_bad++;
        prev_ins = insert;
        cyc++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        coin1  = 1'b0;
        coin2  = 1'b0;
        coin5  = 1'b0;
        reset_stats();

        vecs[0] = '{"coin2_clean",      '0,                                    span(0, 9),                 '0,          0, 1, 0, 0, 7};
        vecs[1] = '{"coin1_bounce",     span(0,0)|span(2,2)|span(4,4)|span(6,15), '0,                       '0,          1, 0, 0, 0, 13};
        vecs[2] = '{"coin1_coin5_same", span(0, 9),                            '0,                         span(0, 9),  0, 0, 0, 1, -1};
        vecs[3] = '{"coin5_then_coin1", span(3, 12),                           '0,                         span(0, 9),  0, 0, 1, 1, 7};
        vecs[4] = '{"glitch_3_samples", '0,                                    '0,                         span(0, 2),  0, 0, 0, 0, -1};
        vecs[5] = '{"stable_4_samples", '0,                                    '0,                         span(0, 3),  0, 0, 1, 0, 7};
        vecs[6] = '{"lockout_last_cyc", span(9, 18),                           span(0, 9),                 '0,          0, 1, 0, 1, 7};
        vecs[7] = '{"after_lockout",    span(10, 19),                          span(0, 9),                 '0,          1, 1, 0, 0, 7};
        vecs[8] = '{"coin2_twice",      '0,                                    span(0, 9)|span(25, 34),    '0,          0, 2, 0, 0, 7};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_insert", int'(insert), int'(C_I0));
        check("reset_reject", int'(coin_reject), 0);
        check("reset_jam", int'(jam), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven scenarios: 48 pattern steps plus 16 idle steps.
        for (int v = 0; v < 9; v++) begin
            reset_stats();
            for (int s = 0; s < 64; s++) begin
                if (s < 48) run_cycle(vecs[v].c1[s], vecs[v].c2[s], vecs[v].c5[s], 1'b0);
                else        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            end
            $display("vector %s: I1=%0d I2=%0d I5=%0d reject=%0d first=%0d jam=%0d",
                     vecs[v].name, n1, n2, n5, nrej, first_ins, jam_cnt);
            check({vecs[v].name, ".n1"},    n1,        vecs[v].n1);
            check({vecs[v].name, ".n2"},    n2,        vecs[v].n2);
            check({vecs[v].name, ".n5"},    n5,        vecs[v].n5);
            check({vecs[v].name, ".rej"},   nrej,      vecs[v].rej);
            check({vecs[v].name, ".first"}, first_ins, vecs[v].first);
            check({vecs[v].name, ".jam"},   jam_cnt,   0);
            check({vecs[v].name, ".viol"},  viol,      0);
        end

        // Jam: coin2 held 100 steps, coin1 dropped in while jammed.
        reset_stats();
        for (int s = 0; s < 140; s++) begin
            run_cycle(s >= 80 && s < 90, s < 100, 1'b0, 1'b0);
        end
        $display("jam sequence: I1=%0d I2=%0d reject=%0d jam_first=%0d jam_last=%0d jam_cycles=%0d",
                 n1, n2, nrej, jam_first, jam_last, jam_cnt);
        check("jam.n2",        n2,        1);
        check("jam.n1",        n1,        0);
        check("jam.rej",       nrej,      1);
        check("jam.first",     jam_first, 70);
        check("jam.last",      jam_last,  105);
        check("jam.cycles",    jam_cnt,   36);
        check("jam.viol",      viol,      0);

        // Reset in the middle of coin5 debounce: the coin is lost.
        reset_stats();
        for (int s = 0; s < 40; s++) begin
            run_cycle(1'b0, 1'b0, s < 6, s >= 3 && s < 6);
        end
        $display("reset during debounce: I5=%0d reject=%0d bad_during_reset=%0d", n5, nrej, rst_bad);
        check("rstdb.n5",      n5,      0);
        check("rstdb.rej",     nrej,    0);
        check("rstdb.outputs", rst_bad, 0);

        // Asynchronous reset while an insert pulse is on the output.
        reset_stats();
        for (int s = 0; s < 7; s++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rstasync.pre_insert", int'(insert), int'(C_I2));
        reset = 1'b1;
        #1;
        check("rstasync.insert", int'(insert), int'(C_I0));
        check("rstasync.reject", int'(coin_reject), 0);
        @(negedge clk);
        reset_stats();
        for (int s = 0; s < 30; s++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        $display("reset during insert: I2 after release=%0d reject=%0d", n2, nrej);
        check("rstasync.after_n2",  n2,   0);
        check("rstasync.after_rej", nrej, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
